// File: rtl/dmtd_meas_ctrl.sv
// DMTD measurement sequencer: times beat_a->beat_b phase and beat_a period, averages 2^n periods.
// Optional DMTD_DEGLITCH_EN: edges need 2 low samples then 2 high samples (1 extra cycle latency).
module dmtd_meas_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT_CYC  = 60000,
  parameter int unsigned AVG_MAX_LOG2 = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_a,
  input  logic             beat_b,
  input  logic             start,
  input  logic [2:0]       avg_log2,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] phase_avg,
  output logic [CNT_W-1:0] period_avg,
  output logic [1:0]       err
);
  localparam int unsigned ACC_W = CNT_W + AVG_MAX_LOG2;
  localparam int unsigned SMP_W = AVG_MAX_LOG2 + 1;
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StWaitA, StMeas, StDone} state_e;

  logic rise_a, rise_b;

`ifdef DMTD_DEGLITCH_EN
  // [0] is the newest registered sample
  logic [2:0] hist_a_q, hist_a_d, hist_b_q, hist_b_d;

  always_comb begin
    hist_a_d = {hist_a_q[1:0], beat_a};
    hist_b_d = {hist_b_q[1:0], beat_b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_a_q <= '0;
      hist_b_q <= '0;
    end else begin
      hist_a_q <= hist_a_d;
      hist_b_q <= hist_b_d;
    end
  end

  assign rise_a = beat_a & hist_a_q[0] & ~hist_a_q[1] & ~hist_a_q[2];
  assign rise_b = beat_b & hist_b_q[0] & ~hist_b_q[1] & ~hist_b_q[2];
`else
  logic beat_a_q, beat_a_d, beat_b_q, beat_b_d;

  always_comb begin
    beat_a_d = beat_a;
    beat_b_d = beat_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_a_q <= 1'b0;
      beat_b_q <= 1'b0;
    end else begin
      beat_a_q <= beat_a_d;
      beat_b_q <= beat_b_d;
    end
  end

  assign rise_a = beat_a & ~beat_a_q;
  assign rise_b = beat_b & ~beat_b_q;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             got_b_q, got_b_d;
  logic [ACC_W-1:0] phase_acc_q, phase_acc_d;
  logic [ACC_W-1:0] period_acc_q, period_acc_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [2:0]       n_q, n_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] phase_avg_q, phase_avg_d;
  logic [CNT_W-1:0] period_avg_q, period_avg_d;
  logic [SMP_W-1:0] smp_tgt;
  logic             enter_done;

  assign smp_tgt = SMP_W'(1) << n_q;

  // cnt holds cycles elapsed since the qualifying edge; the register reads 1 the cycle after it
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    got_b_d      = got_b_q;
    phase_acc_d  = phase_acc_q;
    period_acc_d = period_acc_q;
    smp_d        = smp_q;
    n_d          = n_q;
    err_d        = err_q;
    phase_avg_d  = phase_avg_q;
    period_avg_d = period_avg_q;
    enter_done   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          n_d          = (32'(avg_log2) > AVG_MAX_LOG2) ? 3'(AVG_MAX_LOG2) : avg_log2;
          phase_acc_d  = '0;
          period_acc_d = '0;
          smp_d        = '0;
          err_d        = '0;
          got_b_d      = 1'b0;
          cnt_d        = CNT_W'(1);
          state_d      = StWaitA;
        end
      end
      StWaitA: begin
        if (rise_a) begin
          cnt_d   = CNT_W'(1);
          got_b_d = 1'b0;
          state_d = StMeas;
        end else if (cnt_q >= TimeoutCnt) begin
          err_d[0]   = 1'b1;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StMeas: begin
        if (cnt_q < TimeoutCnt) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Phase is taken before the period closes so a coincident edge gives phase == period
        if (rise_b && !got_b_q) begin
          phase_acc_d = phase_acc_q + ACC_W'(cnt_q);
          got_b_d     = 1'b1;
        end
        if (rise_a) begin
          if (!got_b_q && !rise_b) begin
            err_d[1]   = 1'b1;
            enter_done = 1'b1;
          end else begin
            period_acc_d = period_acc_q + ACC_W'(cnt_q);
            smp_d        = smp_q + SMP_W'(1);
            cnt_d        = CNT_W'(1);
            got_b_d      = 1'b0;
            if (smp_d == smp_tgt) begin
              enter_done = 1'b1;
            end
          end
        end else if (cnt_q >= TimeoutCnt) begin
          err_d[0]   = 1'b1;
          enter_done = 1'b1;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_done) begin
      state_d      = StDone;
      phase_avg_d  = CNT_W'(phase_acc_d >> n_q);
      period_avg_d = CNT_W'(period_acc_d >> n_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      got_b_q      <= 1'b0;
      phase_acc_q  <= '0;
      period_acc_q <= '0;
      smp_q        <= '0;
      n_q          <= '0;
      err_q        <= '0;
      phase_avg_q  <= '0;
      period_avg_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      got_b_q      <= got_b_d;
      phase_acc_q  <= phase_acc_d;
      period_acc_q <= period_acc_d;
      smp_q        <= smp_d;
      n_q          <= n_d;
      err_q        <= err_d;
      phase_avg_q  <= phase_avg_d;
      period_avg_q <= period_avg_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign res_valid  = (state_q == StDone);
  assign phase_avg  = phase_avg_q;
  assign period_avg = period_avg_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dmtd_meas_ctrl.sv
// Bench for dmtd_meas_ctrl: edge-list stimulus, period-level result model, per-cycle compare.
module tb_dmtd_meas_ctrl;
`ifdef DMTD_DEGLITCH_EN
  localparam int DG = 1;
`else
  localparam int DG = 0;
`endif
  localparam int H = 200;       // beat high time in cycles
  localparam int NEVER = 1 << 30;

  logic        clk, rst, beat_a, beat_b, start, start_t, res_ready, res_ready_t;
  logic [2:0]  avg_log2;
  logic        busy, res_valid, busy_t, res_valid_t;
  logic [15:0] phase_avg, period_avg, phase_t, period_t;
  logic [1:0]  err, err_t;

  dmtd_meas_ctrl u_dut (
    .clk(clk), .rst(rst), .beat_a(beat_a), .beat_b(beat_b), .start(start),
    .avg_log2(avg_log2), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .phase_avg(phase_avg), .period_avg(period_avg), .err(err)
  );

  dmtd_meas_ctrl #(.TIMEOUT_CYC(200)) u_to (
    .clk(clk), .rst(rst), .beat_a(beat_a), .beat_b(beat_b), .start(start_t),
    .avg_log2(avg_log2), .busy(busy_t), .res_valid(res_valid_t), .res_ready(res_ready_t),
    .phase_avg(phase_t), .period_avg(period_t), .err(err_t)
  );

  int total = 0;
  int bad = 0;
  int cyc;
  int ra[$], rb[$], rg[$];   // edge offsets relative to the test base
  int qa[$], qb[$], qg[$];   // absolute edge cycles seen by the driver

  // Expected result of the measurement in flight
  bit m_active = 0;
  bit m_retired = 0;
  int m_busy_cyc, m_rv_cyc, m_phase, m_period, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Beat driver: beat is high for H cycles from each listed edge; qg adds 1-cycle glitches
  initial begin
    logic ba, bb;
    cyc = 0;
    beat_a = 0;
    beat_b = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      ba = 0;
      bb = 0;
      foreach (qa[i]) if (cyc >= qa[i] && cyc < qa[i] + H) ba = 1;
      foreach (qb[i]) if (cyc >= qb[i] && cyc < qb[i] + H) bb = 1;
      foreach (qg[i]) if (cyc == qg[i]) bb = 1;
      beat_a = ba;
      beat_b = bb;
    end
  end

  // Per-cycle compare of the main DUT against the expected result
  initial begin
    bit ev, eb;
    forever begin
      @(negedge clk);
      if (m_active) begin
        eb = (cyc >= m_busy_cyc) && !m_retired;
        ev = (cyc >= m_rv_cyc) && !m_retired;
        check("busy", 32'(busy), 32'(eb));
        check("res_valid", 32'(res_valid), 32'(ev));
        if (ev && res_valid === 1'b1) begin
          check("phase_avg", 32'(phase_avg), 32'(m_phase));
          if (m_err != 2) check("period_avg", 32'(period_avg), 32'(m_period));
          check("err", 32'(err), 32'(m_err));
          if (res_ready === 1'b1) m_retired = 1;
        end
      end else begin
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_res_valid", 32'(res_valid), 32'd0);
      end
    end
  end

  task automatic load_edges(input int base);
    qa.delete(); qb.delete(); qg.delete();
    foreach (ra[i]) qa.push_back(base + ra[i]);
    foreach (rb[i]) qb.push_back(base + rb[i]);
    foreach (rg[i]) qg.push_back(base + rg[i]);
  endtask

  // Period-level model: first beat_b edge in (a_i, a_i+1] gives the phase of period i
  task automatic model(input int n);
    int acc_ph, acc_pr, cntn, e, last, fb;
    acc_ph = 0; acc_pr = 0; cntn = 0; e = 0; last = -1;
    for (int i = 0; i + 1 < qa.size() && last < 0; i++) begin
      fb = -1;
      foreach (qb[j]) if (fb < 0 && qb[j] > qa[i] && qb[j] <= qa[i+1]) fb = qb[j];
      if (fb < 0) begin
        e = 2;
        last = qa[i+1];
      end else begin
        acc_ph += fb - qa[i];
        acc_pr += qa[i+1] - qa[i];
        cntn++;
        if (cntn == (1 << n)) last = qa[i+1];
      end
    end
    m_phase  = acc_ph >> n;
    m_period = acc_pr >> n;
    m_err    = e;
    m_rv_cyc = (last < 0) ? NEVER : last + 1 + DG;
  endtask

  task automatic run_meas(input int n, input int lp, input int lpr, input int le, input int rdly);
    int s, k;
    @(posedge clk); #1;
    s = cyc;
    load_edges(s + 5);
    model(n);
    m_busy_cyc = s + 1;
    m_retired  = 0;
    m_active   = 1;
    start      = 1;
    avg_log2   = 3'(n);
    res_ready  = 0;
    @(posedge clk); #1;
    start = 0;
    k = 0;
    while (res_valid !== 1'b1 && k < 12000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 12000) begin
      check("res_valid_timeout", 32'(res_valid), 32'd1);
    end else begin
      check("latency", 32'(cyc), 32'(m_rv_cyc));
      check("lit_phase", 32'(phase_avg), 32'(lp));
      if (le != 2) check("lit_period", 32'(period_avg), 32'(lpr));
      check("lit_err", 32'(err), 32'(le));
    end
    @(posedge clk); #1;
    start = 1;  // must be ignored while in DONE
    @(posedge clk); #1;
    start = 0;
    repeat (rdly) @(posedge clk);
    #1 res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    repeat (2) @(negedge clk);
    m_active = 0;
  endtask

  initial begin
    int s, k;
    rst = 1; start = 0; start_t = 0; avg_log2 = 0; res_ready = 0; res_ready_t = 0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_phase", 32'(phase_avg), 32'd0);
    check("rst_period", 32'(period_avg), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid_t", 32'(res_valid_t), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 0;

    ra = {0, 1000, 2000, 3000, 4000}; rb = {100, 1100, 2100, 3100}; rg = {};
    run_meas(2, 100, 1000, 0, 5);

    ra = {0, 1000, 2000}; rb = {99, 1102}; rg = {};
    run_meas(1, 100, 1000, 0, 0);

    ra = {0, 500}; rb = {0, 500}; rg = {};
    run_meas(0, 500, 500, 0, 1);

    // Reset in the middle of a measurement
    ra = {0, 1000, 2000, 3000, 4000}; rb = {100, 1100, 2100, 3100}; rg = {};
    @(posedge clk); #1;
    s = cyc;
    load_edges(s + 5);
    m_busy_cyc = s + 1; m_rv_cyc = NEVER; m_retired = 0; m_active = 1;
    start = 1; avg_log2 = 3'd2;
    @(posedge clk); #1;
    start = 0;
    repeat (1500) @(posedge clk);
    #2;
    m_active = 0;
    rst = 1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(res_valid), 32'd0);
    check("midrst_phase", 32'(phase_avg), 32'd0);
    check("midrst_period", 32'(period_avg), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(posedge clk); #3 rst = 0;

    run_meas(2, 100, 1000, 0, 2);

    ra = {0, 800}; rb = {}; rg = {};
    run_meas(3, 0, 0, 2, 1);

    // Timeout on the short-timeout instance with beat_a stuck low
    @(posedge clk); #1;
    ra = {}; rb = {}; rg = {};
    load_edges(0);
    s = cyc;
    avg_log2 = 3'd2;
    start_t = 1;
    @(posedge clk); #1;
    start_t = 0;
    k = 0;
    while (res_valid_t !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("to_latency", 32'(cyc), 32'(s + 201));
    check("to_err", 32'(err_t), 32'd1);
    check("to_phase", 32'(phase_t), 32'd0);
    check("to_period", 32'(period_t), 32'd0);
    @(posedge clk); #1;
    start_t = 1;
    repeat (10) begin
      @(negedge clk);
      check("to_hold_valid", 32'(res_valid_t), 32'd1);
      check("to_hold_busy", 32'(busy_t), 32'd1);
      check("to_hold_err", 32'(err_t), 32'd1);
      check("to_hold_phase", 32'(phase_t), 32'd0);
      @(posedge clk); #1;
      start_t = 0;
    end
    res_ready_t = 1;
    @(negedge clk);
    check("to_hs_valid", 32'(res_valid_t), 32'd1);
    @(posedge clk); #1;
    res_ready_t = 0;
    @(negedge clk);
    check("to_after_valid", 32'(res_valid_t), 32'd0);
    check("to_after_busy", 32'(busy_t), 32'd0);

`ifdef DMTD_DEGLITCH_EN
    ra = {0, 1000}; rb = {100}; rg = {50};
    run_meas(0, 100, 1000, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
